// File: rtl/suma3_serial_ctrl.sv
// Bit-serial three-operand adder sequencer driving an external 5-input column compressor.
// One bit column per clock, LSB first; result is N+2 bits and registered.
module suma3_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic [N-1:0] op_c,
  output logic         busy,
  output logic         done,
  output logic [N+1:0] result,
  output logic         err,
  output logic         col_a,
  output logic         col_b,
  output logic         col_c,
  output logic         col_ca1,
  output logic         col_ca2,
  input  logic         col_s,
  input  logic         col_c1,
  input  logic         col_c2,
  input  logic         col_c3
);

  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST_COL = CW'(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  c_q, c_d;
  logic [CW-1:0] col_q, col_d;
  logic          c1_q, c1_d;
  logic          c2_1_q, c2_1_d;
  logic          c2_2_q, c2_2_d;
  logic [N+1:0]  result_q, result_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and datapath update for the column sequencer
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    col_d    = col_q;
    c1_d     = c1_q;
    c2_1_d   = c2_1_q;
    c2_2_d   = c2_2_q;
    result_d = result_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_d      = op_a;
          b_d      = op_b;
          c_d      = op_c;
          col_d    = '0;
          c1_d     = 1'b0;
          c2_1_d   = 1'b0;
          c2_2_d   = 1'b0;
          result_d = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        // Operand registers shift right with zero fill, so flush columns see 0
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        c_d      = c_q >> 1;
        result_d = {col_s, result_q[N+1:1]};
        c1_d     = col_c1;
        c2_2_d   = c2_1_q;
        c2_1_d   = col_c2;
        err_d    = err_q | col_c3;
        col_d    = col_q + CW'(1);
        if (col_q == LAST_COL) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Any carry left over after the last column means the compressor misbehaved
          err_d   = err_q | col_c3 | col_c1 | c2_1_q | col_c2;
          col_d   = '0;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      col_q    <= '0;
      c1_q     <= 1'b0;
      c2_1_q   <= 1'b0;
      c2_2_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      col_q    <= col_d;
      c1_q     <= c1_d;
      c2_1_q   <= c2_1_d;
      c2_2_q   <= c2_2_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign err     = err_q;
  // busy_q is high exactly in RUN, so it gates the column outputs off elsewhere
  assign col_a   = busy_q & a_q[0];
  assign col_b   = busy_q & b_q[0];
  assign col_c   = busy_q & c_q[0];
  assign col_ca1 = busy_q & c1_q;
  assign col_ca2 = busy_q & c2_2_q;

endmodule

// File: tb/tb_suma3_serial_ctrl.sv
// Directed self-checking bench for suma3_serial_ctrl (N=8) with a popcount compressor model.
module tb_suma3_serial_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] op_a, op_b, op_c;
  logic         busy, done, err;
  logic [N+1:0] result;
  logic         col_a, col_b, col_c, col_ca1, col_ca2;
  logic         col_s, col_c1, col_c2, col_c3;

  int checks = 0;
  int errors = 0;
  int tb_col = 0;
  logic inject_c3 = 1'b0;
  logic seen_ca = 1'b0;
  logic [2:0] pc;

  suma3_serial_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .busy(busy), .done(done), .result(result), .err(err),
    .col_a(col_a), .col_b(col_b), .col_c(col_c),
    .col_ca1(col_ca1), .col_ca2(col_ca2),
    .col_s(col_s), .col_c1(col_c1), .col_c2(col_c2), .col_c3(col_c3)
  );

  always #5 clk = ~clk;

  // Compressor model: weighted popcount of the five column inputs
  always_comb begin
    pc = 3'(col_a) + 3'(col_b) + 3'(col_c) + 3'(col_ca1) + 3'(col_ca2);
    col_s  = pc[0];
    col_c1 = pc[1];
    col_c2 = pc[2];
    col_c3 = inject_c3 && busy && (tb_col == 2);
  end

  always @(posedge clk or posedge rst) begin
    if (rst || !busy) tb_col <= 0;
    else tb_col <= tb_col + 1;
  end

  always @(negedge clk) begin
    if (col_ca1 || col_ca2) seen_ca = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [N+1:0] exp_res, input logic exp_err);
    @(negedge clk);
    op_a = a; op_b = b; op_c = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_clr"}, result, 0);
    wait_done(tag, N + 2);
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_cols_idle"}, {col_a, col_b, col_c, col_ca1, col_ca2}, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_c = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {busy, done, err}, 0);
    check("rst_result", result, 0);
    check("rst_cols", {col_a, col_b, col_c, col_ca1, col_ca2}, 0);
    @(negedge clk);
    rst = 1'b0;

    seen_ca = 1'b0;
    run_op("max", 8'd255, 8'd255, 8'd255, 10'h2FD, 1'b0);
    check("max_carries_used", seen_ca, 1);

    seen_ca = 1'b0;
    run_op("zero", 8'd0, 8'd0, 8'd0, 10'h000, 1'b0);
    check("zero_no_carry", seen_ca, 0);

    run_op("mix", 8'd170, 8'd85, 8'd1, 10'h100, 1'b0);
    run_op("ones", 8'd1, 8'd1, 8'd1, 10'h003, 1'b0);

    // start held high: back-to-back runs, operand glitch mid-RUN ignored
    @(negedge clk);
    op_a = 8'd7; op_b = 8'd9; op_c = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    check("b2b1_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    op_a = 8'd100; op_b = 8'd100; op_c = 8'd100;
    @(posedge clk); #1;
    op_a = 8'd7; op_b = 8'd9; op_c = 8'd11;
    wait_done("b2b1", N + 2 - 4);
    check("b2b1_result", result, 27);
    @(posedge clk); #1;
    check("b2b_done_start_ignored", {busy, done}, 0);
    @(posedge clk); #1;
    check("b2b2_busy", busy, 1);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b2", N + 2 - 2);
    check("b2b2_result", result, 27);
    @(posedge clk); #1;
    check("b2b2_no_requeue", {busy, done}, 0);

    // Reset in the middle of a run
    @(negedge clk);
    op_a = 8'd255; op_b = 8'd255; op_c = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_col", tb_col, 4);
    rst = 1'b1;
    #1;
    check("abort_state", {busy, done, err}, 0);
    check("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic saw_done;
      saw_done = 1'b0;
      repeat (15) begin
        @(posedge clk); #1;
        if (done || busy) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 0);
    end
    run_op("after_abort", 8'd200, 8'd100, 8'd50, 10'd350, 1'b0);

    // Overflow flag from the compressor, then cleared by the next start
    inject_c3 = 1'b1;
    run_op("c3_err", 8'd1, 8'd2, 8'd3, 10'd6, 1'b1);
    inject_c3 = 1'b0;
    run_op("c3_clear", 8'd1, 8'd2, 8'd3, 10'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
